// File: rtl/fofb_trig_pkg.sv
// fofb_trig_pkg: shared state encoding, default widths and synchroniser depth
package fofb_trig_pkg;
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ARMED   = 3'd1,
      DELAY   = 3'd2,
      PULSE   = 3'd3,
      HOLDOFF = 3'd4
   } state_t;
   localparam int DEF_DLY_W   = 16;
   localparam int DEF_PW_W    = 8;
   localparam int DEF_CNT_W   = 16;
   localparam int SYNC_STAGES = 2;
endpackage

// File: rtl/fofb_trig_sequencer_sync.sv
// trig_sync_edge: synchronises an async level and emits one pulse per rising edge, 3 edges after first sample
module trig_sync_edge
   import fofb_trig_pkg::*;
(
   input  logic clk,
   input  logic Reset,
   input  logic d_async,
   output logic edge_pulse
);
   logic [SYNC_STAGES-1:0] sync;
   logic q, qd;
   // synchroniser chain, then registered rising-edge detect on the settled level
   always_ff @(posedge clk) begin
      if (Reset) begin
         sync       <= '0;
         q          <= 1'b0;
         qd         <= 1'b0;
         edge_pulse <= 1'b0;
      end else begin
         sync       <= {sync[SYNC_STAGES-2:0], d_async};
         q          <= sync[SYNC_STAGES-1];
         qd         <= q;
         edge_pulse <= q & ~qd;
      end
   end
endmodule

// File: rtl/fofb_trig_sequencer.sv
// fofb_trig_sequencer: turns external/software triggers into delayed, width-controlled DAC update strobes
module fofb_trig_sequencer
   import fofb_trig_pkg::*;
#(
   parameter int DLY_W = DEF_DLY_W,
   parameter int PW_W  = DEF_PW_W,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             Reset,
   input  logic             enable,
   input  logic             arm,
   input  logic             trig,
   input  logic             sw_trig,
   input  logic [DLY_W-1:0] delay,
   input  logic [PW_W-1:0]  pulse_width,
   input  logic [DLY_W-1:0] holdoff,
   input  logic [CNT_W-1:0] burst_len,
   output logic             trig_out,
   output logic             busy,
   output logic             armed,
   output logic [CNT_W-1:0] fired_cnt,
   output logic [CNT_W-1:0] missed_cnt
);
   state_t           state, nxt;
   logic [DLY_W-1:0] dcnt, hcnt;
   logic [PW_W-1:0]  pcnt;
   logic [CNT_W-1:0] rem;
   logic             rem_inf, ext_ev, ev, more;

   trig_sync_edge u_sync (
      .clk        (clk),
      .Reset      (Reset),
      .d_async    (trig),
      .edge_pulse (ext_ev)
   );

   assign ev    = ext_ev | sw_trig;
   assign busy  = (state == DELAY) | (state == PULSE) | (state == HOLDOFF);
   assign armed = (state == ARMED);

   // next state; in PULSE the burst count has not yet been decremented, so look one ahead
   always_comb begin
      nxt  = state;
      more = rem_inf | ((state == PULSE) ? (rem > CNT_W'(1)) : (rem != '0));
      case (state)
         IDLE:    nxt = (arm & enable) ? ARMED : IDLE;
         ARMED:   nxt = ev ? ((delay == '0) ? PULSE : DELAY) : ARMED;
         DELAY:   nxt = (dcnt <= DLY_W'(1)) ? PULSE : DELAY;
         PULSE:   nxt = (pcnt > PW_W'(1)) ? PULSE : (hcnt != '0) ? HOLDOFF : more ? ARMED : IDLE;
         HOLDOFF: nxt = (hcnt > DLY_W'(1)) ? HOLDOFF : more ? ARMED : IDLE;
         default: nxt = IDLE;
      endcase
      if (!enable) nxt = IDLE;
   end

   // state, working counters, statistics and the registered strobe
   always_ff @(posedge clk) begin
      if (Reset) begin
         state      <= IDLE;
         trig_out   <= 1'b0;
         dcnt       <= '0;
         hcnt       <= '0;
         pcnt       <= '0;
         rem        <= '0;
         rem_inf    <= 1'b0;
         fired_cnt  <= '0;
         missed_cnt <= '0;
      end else begin
         state    <= nxt;
         trig_out <= (nxt == PULSE);
         if (state == IDLE && nxt == ARMED) begin
            rem        <= burst_len;
            rem_inf    <= (burst_len == '0);
            fired_cnt  <= '0;
            missed_cnt <= '0;
         end
         if (state == ARMED && ev && enable) begin
            dcnt <= delay;
            pcnt <= (pulse_width == '0) ? PW_W'(1) : pulse_width;
            hcnt <= holdoff;
         end
         if (state == DELAY && dcnt != '0) dcnt <= dcnt - DLY_W'(1);
         if (state == PULSE && enable) begin
            if (pcnt > PW_W'(1)) pcnt <= pcnt - PW_W'(1);
            else begin
               fired_cnt <= (&fired_cnt) ? fired_cnt : fired_cnt + CNT_W'(1);
               rem       <= (rem_inf || rem == '0) ? rem : rem - CNT_W'(1);
            end
         end
         if (state == HOLDOFF && hcnt != '0) hcnt <= hcnt - DLY_W'(1);
         if (busy && ev && enable && !(&missed_cnt)) missed_cnt <= missed_cnt + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_fofb_trig_sequencer.sv
// tb_fofb_trig_sequencer: directed vectors with hand-computed expectations for the trigger sequencer
module tb_fofb_trig_sequencer;
   logic        clk, Reset, enable, arm, trig, sw_trig;
   logic [15:0] delay, holdoff, burst_len;
   logic [7:0]  pulse_width;
   logic        trig_out, busy, armed;
   logic [15:0] fired_cnt, missed_cnt;
   logic        s_trig_out, s_busy, s_armed;
   logic [3:0]  s_fired, s_missed;
   int          n_vec, n_err;

   fofb_trig_sequencer dut (
      .clk(clk), .Reset(Reset), .enable(enable), .arm(arm), .trig(trig), .sw_trig(sw_trig),
      .delay(delay), .pulse_width(pulse_width), .holdoff(holdoff), .burst_len(burst_len),
      .trig_out(trig_out), .busy(busy), .armed(armed), .fired_cnt(fired_cnt), .missed_cnt(missed_cnt)
   );

   fofb_trig_sequencer #(.CNT_W(4)) u_small (
      .clk(clk), .Reset(Reset), .enable(enable), .arm(arm), .trig(trig), .sw_trig(sw_trig),
      .delay(delay), .pulse_width(pulse_width), .holdoff(holdoff), .burst_len(burst_len[3:0]),
      .trig_out(s_trig_out), .busy(s_busy), .armed(s_armed), .fired_cnt(s_fired), .missed_cnt(s_missed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic do_arm;
      arm = 1'b1;
      tick;
      arm = 1'b0;
   endtask

   task automatic pulse_sw;
      sw_trig = 1'b1;
      tick;
      sw_trig = 1'b0;
   endtask

   task automatic wait_armed(input int bound);
      for (int i = 0; i < bound && !armed; i++) tick;
      chk("wait_armed", armed, 1);
   endtask

   initial begin
      logic any_out;
      n_vec = 0; n_err = 0;
      Reset = 1'b1; enable = 1'b0; arm = 1'b0; trig = 1'b0; sw_trig = 1'b0;
      delay = '0; holdoff = '0; burst_len = '0; pulse_width = '0;
      repeat (3) tick;
      chk("rst_out", trig_out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_armed", armed, 0);
      chk("rst_fired", fired_cnt, 0);
      chk("rst_missed", missed_cnt, 0);
      Reset = 1'b0;
      tick;

      // single shot: strobe E+11..E+14, IDLE at E+20
      enable = 1'b1; burst_len = 1; delay = 10; pulse_width = 4; holdoff = 5;
      pulse_sw;
      chk("idle_ev_ignored", armed | busy, 0);
      do_arm;
      chk("ss_armed", armed, 1);
      sw_trig = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         tick;
         sw_trig = 1'b0;
         chk($sformatf("ss_out_%0d", i), trig_out, (i >= 11 && i <= 14) ? 1 : 0);
      end
      chk("ss_busy", busy, 0);
      chk("ss_armed_end", armed, 0);
      chk("ss_fired", fired_cnt, 1);
      chk("ss_missed", missed_cnt, 0);

      // external async edge, zero delay and zero width
      delay = 0; pulse_width = 0; holdoff = 0;
      do_arm;
      #3 trig = 1'b1;
      for (int n = 0; n <= 5; n++) begin
         @(posedge clk);
         #1;
         chk($sformatf("ext_out_e%0d", n), trig_out, (n == 4) ? 1 : 0);
      end
      trig = 1'b0;
      chk("ext_fired", fired_cnt, 1);
      chk("ext_idle", armed | busy, 0);

      // burst of 3 with holdoff 20, five triggers 8 apart: accepted at 0 and 24, dropped at 8,16,32
      burst_len = 3; delay = 0; pulse_width = 1; holdoff = 20;
      do_arm;
      for (int c = 0; c < 40; c++) begin
         sw_trig = (c % 8 == 0 && c <= 32);
         tick;
      end
      sw_trig = 1'b0;
      chk("burst_fired_2", fired_cnt, 2);
      chk("burst_missed", missed_cnt, 3);
      chk("burst_busy", busy, 1);
      wait_armed(20);
      pulse_sw;
      chk("burst_3rd_out", trig_out, 1);
      repeat (22) tick;
      chk("burst_fired_3", fired_cnt, 3);
      chk("burst_idle", armed | busy, 0);
      pulse_sw;
      tick;
      chk("burst_no_4th", trig_out, 0);
      chk("burst_fired_hold", fired_cnt, 3);
      chk("burst_missed_hold", missed_cnt, 3);

      // continuous mode, 100 well-spaced triggers
      burst_len = 0; delay = 1; pulse_width = 2; holdoff = 3;
      do_arm;
      for (int i = 0; i < 100; i++) begin
         pulse_sw;
         repeat (9) tick;
      end
      chk("cont_fired", fired_cnt, 100);
      chk("cont_armed", armed, 1);
      chk("cont_missed", missed_cnt, 0);
      pulse_sw;
      tick;
      chk("cont_pulse_on", trig_out, 1);
      enable = 1'b0;
      tick;
      chk("abort_out", trig_out, 0);
      chk("abort_idle", armed | busy, 0);
      chk("abort_fired", fired_cnt, 100);
      enable = 1'b1;

      // reset in the middle of DELAY
      burst_len = 2; delay = 10; pulse_width = 2; holdoff = 2;
      do_arm;
      pulse_sw;
      pulse_sw;
      chk("rd_missed_pre", missed_cnt, 1);
      chk("rd_busy_pre", busy, 1);
      Reset = 1'b1;
      tick;
      Reset = 1'b0;
      chk("rd_out", trig_out, 0);
      chk("rd_busy", busy, 0);
      chk("rd_armed", armed, 0);
      chk("rd_fired", fired_cnt, 0);
      chk("rd_missed", missed_cnt, 0);
      pulse_sw;
      any_out = 1'b0;
      for (int i = 0; i < 15; i++) begin
         tick;
         any_out |= trig_out;
      end
      chk("rd_no_strobe", any_out, 0);

      // saturation: 20 drops into a 4-bit counter
      burst_len = 1; delay = 200;
      do_arm;
      pulse_sw;
      for (int i = 0; i < 20; i++) begin
         pulse_sw;
         tick;
      end
      chk("sat_small", s_missed, 15);
      chk("sat_wide", missed_cnt, 20);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/fofb_trig_sequencer.md
Name: fofb_trig_sequencer

Overview:
- Accepts an external FOFB timing trigger (asynchronous) or a software trigger and issues a clean, delayed, width-controlled DAC update strobe.
- Supports single-shot, N-shot burst and continuous modes, with holdoff protection and missed-trigger accounting.
- Sits between the timing-system input pin and the DAC update/readback logic; it is the only source of DAC update strobes in the FOFB datapath.

Parameters:
- DLY_W, 16, width of the delay and holdoff registers (cycles)
- PW_W, 8, width of the pulse-width register (cycles)
- CNT_W, 16, width of the burst, fired and missed counters

Ports:
- clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- enable  in  1  sequencer enable; low aborts to IDLE
- arm  in  1  single-cycle pulse; arms the sequencer and latches burst_len
- trig  in  1  external trigger, asynchronous level
- sw_trig  in  1  single-cycle software trigger, clk domain
- delay  in  DLY_W  cycles from accepted edge to strobe start
- pulse_width  in  PW_W  strobe width in cycles; 0 is treated as 1
- holdoff  in  DLY_W  dead cycles after strobe end
- burst_len  in  CNT_W  strobes per arm; 0 means continuous
- trig_out  out  1  registered DAC update strobe
- busy  out  1  high in DELAY, PULSE and HOLDOFF
- armed  out  1  high in ARMED
- fired_cnt  out  CNT_W  strobes issued since the last arm; saturating
- missed_cnt  out  CNT_W  edges ignored since the last arm; saturating

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high. While Reset is high, every output is 0, the state is IDLE and all counters are 0.
- Edge source:
  - trig passes through two synchroniser flops, then a rising-edge register.
  - ext_ev is high for 1 cycle, 3 clk edges after the first edge that samples trig high.
  - ev = ext_ev OR sw_trig. Coincident ext_ev and sw_trig count as one event.
- States:
  - IDLE: all outputs low. arm AND enable moves to ARMED. On that transition, burst_len is latched to rem, rem_inf is set to (burst_len == 0), and fired_cnt and missed_cnt are cleared. ev in IDLE is ignored and not counted.
  - ARMED: ev latches delay, pulse_width and holdoff into working registers.
    - delay == 0: go to PULSE.
    - otherwise: go to DELAY with dcnt = delay.
  - DELAY: decrement dcnt. When dcnt reaches 1, go to PULSE.
  - PULSE: trig_out = 1 for max(pulse_width, 1) cycles.
    - On the last cycle, increment fired_cnt and decrement rem (unless rem_inf).
    - Then go to HOLDOFF, or go straight to the post-holdoff decision if holdoff == 0.
  - HOLDOFF: count holdoff cycles, then:
    - rem_inf OR rem != 0: go to ARMED.
    - otherwise: go to IDLE.
- Latency: with ev high in cycle E, trig_out is first high in cycle E+1+delay. trig_out is registered and glitch-free.
- Events while busy: any ev in DELAY, PULSE or HOLDOFF increments missed_cnt (saturating at all-ones) and is otherwise dropped; there is no queuing.
- Configuration: delay, pulse_width and holdoff changes take effect only at the next accepted event. burst_len is sampled only at arm.
- arm while not IDLE: ignored; there is no re-arm mid-burst.
- enable low in any state: next cycle the state is IDLE and trig_out is 0. A truncated pulse is not counted. Counters hold their values.
- Reset mid-pulse: trig_out is 0 on the cycle after the clk edge that samples Reset high.
- Counter widths: fired_cnt and missed_cnt are CNT_W bits and saturate. dcnt and the holdoff counter are DLY_W bits. The pulse counter is PW_W bits. No wrap-around is permitted on any counter.

Decomposition:
- Shared package fofb_trig_pkg holds:
  - the state enum (IDLE, ARMED, DELAY, PULSE, HOLDOFF) as 3-bit localparams;
  - the default widths;
  - the constant SYNC_STAGES = 2.
- Sub-module trig_sync_edge: 2-flop synchroniser plus rising-edge register, ports clk, Reset, d_async, edge_pulse, with the fixed 3-cycle latency defined above.
- The FSM, counters and output register stay in the top level.

Test Plan:
- Single shot: burst_len=1, delay=10, pulse_width=4, holdoff=5, arm, then sw_trig at cycle E.
  - Required: trig_out high for cycles E+11 to E+14.
  - fired_cnt = 1, then the state is IDLE at E+20.
- External edge, delay=0, pulse_width=0: trig rises asynchronously.
  - Required: trig_out high for exactly 1 cycle, first high 4 clk edges after the first sampling edge.
- Burst with retrigger: burst_len=3, holdoff=20. Drive 5 sw_trig pulses 8 cycles apart.
  - Required: fired_cnt = 3 and missed_cnt equal to the drops during busy (check against the model).
  - A 4th strobe is issued only if an ev arrives in ARMED; state is IDLE after the 3rd strobe's holdoff.
- Continuous mode: burst_len=0, 100 sw_trig pulses spaced wider than delay+width+holdoff.
  - Required: fired_cnt = 100 and the sequencer stays ARMED.
  - Deassert enable during a pulse: trig_out is 0 next cycle, fired_cnt stays 100.
- Reset mid-DELAY: assert Reset for 1 cycle.
  - Required: all outputs and counters are 0 the next cycle.
  - Later ev without a new arm produces no strobe.
- Saturation: CNT_W=4 and 20 ignored events while busy.
  - Required: missed_cnt holds at 15 with no wrap.
